// File: rtl/stack_access_sequencer.sv
// Stack-page bus sequencer for 65C02 push/pull sequences of 0..MAX_BYTES bytes.
// Define STACK_BOUNDS_CHECK_EN to enable the sticky stack_wrap page-wrap flag.
module stack_access_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter int         MAX_BYTES  = 3
) (
  input  logic                           fclk,
  input  logic                           reset_n,
  input  logic                           req,
  input  logic                           op_pull,
  input  logic [$clog2(MAX_BYTES+1)-1:0] count,
  input  logic [8*MAX_BYTES-1:0]         push_data,
  output logic                           ready,
  output logic                           done,
  output logic [8*MAX_BYTES-1:0]         pull_data,
  input  logic [7:0]                     sp_in,
  output logic                           sp_increment,
  output logic                           sp_decrement,
  input  logic                           rdy,
  output logic [15:0]                    addr_out,
  output logic [7:0]                     data_out,
  input  logic [7:0]                     data_in,
  output logic                           rw,
  output logic                           stack_wrap
);

  // state        | meaning
  // ST_IDLE      | waiting for req, ready=1
  // ST_PUSH      | write byte[idx] at SP, then decrement
  // ST_PULL_DUMMY| 6502 dummy read at SP, then increment
  // ST_PULL_READ | read byte[idx] at SP, increment unless last
  // ST_DONE      | one-cycle done pulse
  typedef enum logic [2:0] {
    ST_IDLE, ST_PUSH, ST_PULL_DUMMY, ST_PULL_READ, ST_DONE
  } state_t;

  localparam int            CW  = $clog2(MAX_BYTES+1);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t                 state, state_next;
  logic [CW-1:0]          idx, idx_next;
  logic [CW-1:0]          count_q;
  logic [8*MAX_BYTES-1:0] push_q;
  logic [8*MAX_BYTES-1:0] push_shift;
  logic                   last_read;

  assign push_shift = push_q >> {idx, 3'b000};
  assign last_read  = (idx == count_q - ONE);

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      count_q   <= '0;
      push_q    <= '0;
      pull_data <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (state == ST_IDLE && req) begin
        count_q <= count;
        push_q  <= push_data;
        // a real pull starts from a clean result; count=0 leaves the old one
        if (op_pull && count != '0) pull_data <= '0;
      end
      if (state == ST_PULL_READ && rdy) begin
        for (int b = 0; b < MAX_BYTES; b++) begin
          if (idx == CW'(b)) pull_data[8*b +: 8] <= data_in;
        end
      end
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    ready        = 1'b0;
    done         = 1'b0;
    addr_out     = 16'h0000;
    data_out     = 8'h00;
    rw           = 1'b1;
    sp_increment = 1'b0;
    sp_decrement = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (count == '0) begin
            state_next = ST_DONE;
          end else if (op_pull) begin
            state_next = ST_PULL_DUMMY;
          end else begin
            state_next = ST_PUSH;
            idx_next   = count - ONE;
          end
        end
      end
      ST_PUSH: begin
        addr_out     = {STACK_PAGE, sp_in};
        data_out     = push_shift[7:0];
        rw           = 1'b0;
        sp_decrement = rdy;
        if (rdy) begin
          if (idx == '0) state_next = ST_DONE;
          else           idx_next   = idx - ONE;
        end
      end
      ST_PULL_DUMMY: begin
        addr_out     = {STACK_PAGE, sp_in};
        sp_increment = rdy;
        if (rdy) begin
          state_next = ST_PULL_READ;
          idx_next   = '0;
        end
      end
      ST_PULL_READ: begin
        addr_out = {STACK_PAGE, sp_in};
        if (rdy) begin
          if (last_read) begin
            state_next = ST_DONE;
          end else begin
            sp_increment = 1'b1;
            idx_next     = idx + ONE;
          end
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef STACK_BOUNDS_CHECK_EN
  logic wrap_q;

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else if ((sp_decrement && sp_in == 8'h00) ||
                 (sp_increment && sp_in == 8'hFF)) begin
      wrap_q <= 1'b1;
    end
  end

  assign stack_wrap = wrap_q;
`else
  assign stack_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_stack_access_sequencer.sv
// Randomized self-checking bench for stack_access_sequencer with a stack memory and SP register model.
module tb_stack_access_sequencer;

`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic        fclk, reset_n, req, op_pull, rdy;
  logic [1:0]  count;
  logic [23:0] push_data, pull_data;
  logic        ready, done, sp_increment, sp_decrement, rw, stack_wrap;
  logic [7:0]  sp_in, data_out, data_in;
  logic [15:0] addr_out;

  stack_access_sequencer dut (
    .fclk(fclk), .reset_n(reset_n), .req(req), .op_pull(op_pull), .count(count),
    .push_data(push_data), .ready(ready), .done(done), .pull_data(pull_data),
    .sp_in(sp_in), .sp_increment(sp_increment), .sp_decrement(sp_decrement),
    .rdy(rdy), .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
    .rw(rw), .stack_wrap(stack_wrap)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  // stack pointer register and stack page memory seen by the sequencer
  logic [7:0] sp;
  logic [7:0] mem [256];
  logic       ld_sp, ld_mem;
  logic [7:0] ld_addr, ld_val;

  always @(posedge fclk) begin
    if (ld_sp) sp <= ld_val;
    else if (sp_decrement) sp <= sp - 8'd1;
    else if (sp_increment) sp <= sp + 8'd1;
    if (ld_mem) mem[ld_addr] <= ld_val;
    else if (!rw && rdy && addr_out[15:8] == 8'h01) mem[addr_out[7:0]] <= data_out;
  end

  assign sp_in   = sp;
  assign data_in = mem[addr_out[7:0]];

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] obs_w [$];
  logic [15:0] obs_r [$];
  int          obs_inc, obs_dec, obs_lat, obs_both, obs_stall_pulse, obs_hold, obs_notready;
  logic [23:0] obs_pull;
  logic        obs_done_ready;
  logic [23:0] exp_pull;
  logic        exp_wrap;

  task automatic set_sp(input logic [7:0] v);
    @(negedge fclk); ld_sp = 1'b1; ld_val = v;
    @(negedge fclk); ld_sp = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge fclk); ld_mem = 1'b1; ld_addr = a; ld_val = v;
    @(negedge fclk); ld_mem = 1'b0;
  endtask

  // cycle k after accept (k>=1) needs bus cycles with rdy=1; done follows the last one
  function automatic int exp_latency(input int bus, input logic [31:0] pat);
    int ones = 0;
    if (bus == 0) return 1;
    for (int k = 1; k <= 64; k++) begin
      if (k > 32 || pat[k-1]) ones++;
      if (ones == bus) return k + 1;
    end
    return -1;
  endfunction

  task automatic run_seq(input logic op, input logic [1:0] cnt, input logic [23:0] pd,
                         input logic [31:0] pat);
    logic        prev_stall;
    logic [24:0] prev_bus;
    obs_w.delete(); obs_r.delete();
    obs_inc = 0; obs_dec = 0; obs_both = 0; obs_stall_pulse = 0; obs_hold = 0;
    obs_notready = 0; obs_lat = -1; obs_pull = 24'h0; obs_done_ready = 1'b1;
    prev_stall = 1'b0; prev_bus = '0;
    @(negedge fclk);
    for (int i = 0; i < 20 && !ready; i++) @(negedge fclk);
    req = 1'b1; op_pull = op; count = cnt; push_data = pd; rdy = 1'b1;
    @(negedge fclk);
    req = 1'b0; op_pull = 1'($urandom); count = 2'($urandom); push_data = 24'($urandom);
    for (int cyc = 1; cyc <= 64; cyc++) begin
      rdy = (cyc <= 32) ? pat[cyc-1] : 1'b1;
      #1;
      if (done) begin
        obs_lat = cyc; obs_pull = pull_data; obs_done_ready = ready;
        break;
      end
      if (prev_stall && {addr_out, data_out, rw} !== prev_bus) obs_hold++;
      if (sp_increment && sp_decrement) obs_both++;
      if (!rdy && (sp_increment || sp_decrement)) obs_stall_pulse++;
      if (ready) obs_notready++;
      if (rdy && addr_out[15:8] == 8'h01) begin
        if (!rw) obs_w.push_back({addr_out, data_out});
        else     obs_r.push_back(addr_out);
      end
      if (sp_increment) obs_inc++;
      if (sp_decrement) obs_dec++;
      prev_stall = !rdy;
      prev_bus   = {addr_out, data_out, rw};
      @(negedge fclk);
    end
    rdy = 1'b1;
    if (obs_lat < 0) begin
      n_checks++;
      $display("FAIL seq_timeout no done within 64 cycles (op=%0d count=%0d)", op, cnt);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b0; op_pull = 1'b0; count = 2'd0; push_data = 24'h0; rdy = 1'b1;
    ld_sp = 1'b0; ld_mem = 1'b0; ld_addr = 8'h0; ld_val = 8'h0;
    repeat (3) @(negedge fclk);
    #1;
    n_checks++; if (ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (pull_data !== 24'h0) $display("FAIL rst_pull_data got %h want 000000", pull_data); else n_pass++;
    n_checks++; if (addr_out !== 16'h0) $display("FAIL rst_addr got %h want 0000", addr_out); else n_pass++;
    n_checks++; if (data_out !== 8'h0) $display("FAIL rst_data_out got %h want 00", data_out); else n_pass++;
    n_checks++; if (rw !== 1'b1) $display("FAIL rst_rw got %b want 1", rw); else n_pass++;
    n_checks++; if ({sp_increment, sp_decrement} !== 2'b00) $display("FAIL rst_sp_pulses got %b want 00", {sp_increment, sp_decrement}); else n_pass++;
    n_checks++; if (stack_wrap !== 1'b0) $display("FAIL rst_wrap got %b want 0", stack_wrap); else n_pass++;
    @(negedge fclk); reset_n = 1'b1;
    exp_pull = 24'h0; exp_wrap = 1'b0;
  endtask

  task automatic test_push();
    set_sp(8'hFF);
    run_seq(1'b0, 2'd2, 24'h001234, 32'hFFFF_FFFF);
    n_checks++; if (obs_lat !== 3) $display("FAIL push_latency got %0d want 3", obs_lat); else n_pass++;
    n_checks++; if (obs_w.size() !== 2) $display("FAIL push_writes got %0d want 2", obs_w.size()); else n_pass++;
    if (obs_w.size() == 2) begin
      n_checks++; if (obs_w[0] !== 24'h01FF12) $display("FAIL push_w0 got %h want 01FF12", obs_w[0]); else n_pass++;
      n_checks++; if (obs_w[1] !== 24'h01FE34) $display("FAIL push_w1 got %h want 01FE34", obs_w[1]); else n_pass++;
    end
    n_checks++; if (obs_dec !== 2 || obs_inc !== 0) $display("FAIL push_pulses got dec=%0d inc=%0d want 2/0", obs_dec, obs_inc); else n_pass++;
    n_checks++; if (sp !== 8'hFD) $display("FAIL push_sp got %h want FD", sp); else n_pass++;
  endtask

  task automatic test_pull();
    poke(8'hFD, 8'hAA); poke(8'hFE, 8'hBB); poke(8'hFF, 8'hCC);
    set_sp(8'hFC);
    run_seq(1'b1, 2'd3, 24'h0, 32'hFFFF_FFFF);
    n_checks++; if (obs_lat !== 5) $display("FAIL pull_latency got %0d want 5", obs_lat); else n_pass++;
    n_checks++; if (obs_r.size() !== 4) $display("FAIL pull_reads got %0d want 4", obs_r.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs_r.size(); i++) begin
      n_checks++;
      if (obs_r[i] !== 16'h01FC + 16'(i)) $display("FAIL pull_read_addr[%0d] got %h want %h", i, obs_r[i], 16'h01FC + 16'(i));
      else n_pass++;
    end
    n_checks++; if (obs_w.size() !== 0) $display("FAIL pull_no_writes got %0d want 0", obs_w.size()); else n_pass++;
    n_checks++; if (obs_inc !== 3 || obs_dec !== 0) $display("FAIL pull_pulses got inc=%0d dec=%0d want 3/0", obs_inc, obs_dec); else n_pass++;
    n_checks++; if (obs_pull !== 24'hCCBBAA) $display("FAIL pull_data got %h want CCBBAA", obs_pull); else n_pass++;
    n_checks++; if (sp !== 8'hFF) $display("FAIL pull_sp got %h want FF", sp); else n_pass++;
    exp_pull = 24'hCCBBAA;
  endtask

  task automatic test_stall();
    set_sp(8'h80);
    run_seq(1'b0, 2'd1, 24'h0000A5, 32'hFFFF_FFFC);
    n_checks++; if (obs_lat !== 4) $display("FAIL stall_latency got %0d want 4", obs_lat); else n_pass++;
    n_checks++; if (obs_w.size() !== 1) $display("FAIL stall_writes got %0d want 1", obs_w.size()); else n_pass++;
    if (obs_w.size() == 1) begin
      n_checks++; if (obs_w[0] !== 24'h0180A5) $display("FAIL stall_w0 got %h want 0180A5", obs_w[0]); else n_pass++;
    end
    n_checks++; if (obs_hold !== 0) $display("FAIL stall_hold got %0d changes want 0", obs_hold); else n_pass++;
    n_checks++; if (obs_stall_pulse !== 0) $display("FAIL stall_pulse got %0d want 0", obs_stall_pulse); else n_pass++;
    n_checks++; if (obs_dec !== 1) $display("FAIL stall_dec got %0d want 1", obs_dec); else n_pass++;
    n_checks++; if (sp !== 8'h7F) $display("FAIL stall_sp got %h want 7F", sp); else n_pass++;
  endtask

  task automatic test_count_zero();
    for (int op = 0; op < 2; op++) begin
      set_sp(8'h40);
      run_seq(1'(op), 2'd0, 24'h5A5A5A, 32'hFFFF_FFFF);
      n_checks++; if (obs_lat !== 1) $display("FAIL zero_latency op=%0d got %0d want 1", op, obs_lat); else n_pass++;
      n_checks++; if (obs_w.size() + obs_r.size() !== 0) $display("FAIL zero_bus op=%0d got %0d cycles want 0", op, obs_w.size() + obs_r.size()); else n_pass++;
      n_checks++; if (obs_inc + obs_dec !== 0) $display("FAIL zero_pulses op=%0d got %0d want 0", op, obs_inc + obs_dec); else n_pass++;
      n_checks++; if (obs_pull !== exp_pull) $display("FAIL zero_pull_data op=%0d got %h want %h", op, obs_pull, exp_pull); else n_pass++;
      n_checks++; if (sp !== 8'h40) $display("FAIL zero_sp op=%0d got %h want 40", op, sp); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    n_checks++; if (stack_wrap !== 1'b0) $display("FAIL wrap_before got %b want 0", stack_wrap); else n_pass++;
    set_sp(8'h00);
    run_seq(1'b0, 2'd1, 24'h000077, 32'hFFFF_FFFF);
    #1;
    n_checks++; if (stack_wrap !== WRAP_EN) $display("FAIL wrap_set got %b want %b", stack_wrap, WRAP_EN); else n_pass++;
    n_checks++; if (sp !== 8'hFF) $display("FAIL wrap_sp got %h want FF", sp); else n_pass++;
    set_sp(8'h50);
    run_seq(1'b0, 2'd2, 24'h001122, 32'hFFFF_FFFF);
    #1;
    n_checks++; if (stack_wrap !== WRAP_EN) $display("FAIL wrap_sticky got %b want %b", stack_wrap, WRAP_EN); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    poke(8'h11, 8'h5A); poke(8'h12, 8'h6B); poke(8'h13, 8'h7C);
    set_sp(8'h10);
    @(negedge fclk); req = 1'b1; op_pull = 1'b1; count = 2'd3; rdy = 1'b1;
    @(negedge fclk); req = 1'b0;
    @(negedge fclk);
    @(negedge fclk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", ready); else n_pass++;
    n_checks++; if (pull_data !== 24'h0) $display("FAIL midrst_pull_data got %h want 000000", pull_data); else n_pass++;
    n_checks++; if (addr_out !== 16'h0 || rw !== 1'b1) $display("FAIL midrst_bus got addr=%h rw=%b want 0000/1", addr_out, rw); else n_pass++;
    n_checks++; if ({sp_increment, sp_decrement, done} !== 3'b000) $display("FAIL midrst_pulses got %b want 000", {sp_increment, sp_decrement, done}); else n_pass++;
    @(negedge fclk); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge fclk); #1;
      if (sp_increment || sp_decrement || addr_out != 16'h0 || !rw || !ready || done) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL midrst_quiet got %0d busy cycles want 0", bad); else n_pass++;
    exp_pull = 24'h0; exp_wrap = 1'b0;
  endtask

  task automatic test_random();
    logic        op;
    logic [1:0]  n;
    logic [23:0] pd;
    logic [7:0]  s;
    logic [31:0] pat;
    int          r, bus, lat;
    for (int it = 0; it < 60; it++) begin
      op = 1'($urandom_range(0, 1));
      n  = 2'($urandom_range(0, 3));
      pd = 24'($urandom);
      r  = $urandom_range(0, 7);
      s  = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : (r == 2) ? 8'h01 : (r == 3) ? 8'hFE : 8'($urandom);
      for (int b = 0; b < 32; b++) pat[b] = ($urandom_range(0, 3) != 0);
      set_sp(s);
      if (op) for (int i = 0; i < int'(n); i++) poke(8'(s + 8'(i) + 8'd1), 8'($urandom));
      if (op && n != 2'd0) begin
        exp_pull = 24'h0;
        for (int i = 0; i < int'(n); i++) exp_pull[8*i +: 8] = mem[8'(s + 8'(i) + 8'd1)];
      end
      for (int k = 0; k < int'(n); k++) begin
        if (!op && 8'(s - 8'(k)) == 8'h00) exp_wrap = exp_wrap | WRAP_EN;
        if (op && 8'(s + 8'(k)) == 8'hFF) exp_wrap = exp_wrap | WRAP_EN;
      end
      bus = (n == 2'd0) ? 0 : (op ? int'(n) + 1 : int'(n));
      lat = exp_latency(bus, pat);
      run_seq(op, n, pd, pat);
      #1;
      n_checks++; if (obs_lat !== lat) $display("FAIL rnd%0d_latency got %0d want %0d", it, obs_lat, lat); else n_pass++;
      n_checks++; if (obs_w.size() !== (op ? 0 : int'(n))) $display("FAIL rnd%0d_writes got %0d want %0d", it, obs_w.size(), op ? 0 : int'(n)); else n_pass++;
      for (int k = 0; k < obs_w.size() && !op && k < int'(n); k++) begin
        n_checks++;
        if (obs_w[k] !== {8'h01, 8'(s - 8'(k)), pd[8*(int'(n)-1-k) +: 8]})
          $display("FAIL rnd%0d_w%0d got %h want %h", it, k, obs_w[k], {8'h01, 8'(s - 8'(k)), pd[8*(int'(n)-1-k) +: 8]});
        else n_pass++;
      end
      n_checks++; if (obs_r.size() !== ((op && n != 2'd0) ? int'(n) + 1 : 0)) $display("FAIL rnd%0d_reads got %0d", it, obs_r.size()); else n_pass++;
      for (int k = 0; k < obs_r.size() && op && k <= int'(n); k++) begin
        n_checks++;
        if (obs_r[k] !== {8'h01, 8'(s + 8'(k))}) $display("FAIL rnd%0d_r%0d got %h want %h", it, k, obs_r[k], {8'h01, 8'(s + 8'(k))});
        else n_pass++;
      end
      n_checks++; if (obs_inc !== (op ? int'(n) : 0) || obs_dec !== (op ? 0 : int'(n))) $display("FAIL rnd%0d_pulses got inc=%0d dec=%0d", it, obs_inc, obs_dec); else n_pass++;
      n_checks++; if (sp !== (op ? 8'(s + 8'(n)) : 8'(s - 8'(n)))) $display("FAIL rnd%0d_sp got %h start %h", it, sp, s); else n_pass++;
      n_checks++; if (obs_pull !== exp_pull) $display("FAIL rnd%0d_pull_data got %h want %h", it, obs_pull, exp_pull); else n_pass++;
      n_checks++; if (stack_wrap !== exp_wrap) $display("FAIL rnd%0d_wrap got %b want %b", it, stack_wrap, exp_wrap); else n_pass++;
      n_checks++;
      if (obs_both + obs_stall_pulse + obs_hold + obs_notready !== 0 || obs_done_ready !== 1'b0)
        $display("FAIL rnd%0d_protocol both=%0d stall_pulse=%0d hold=%0d ready_busy=%0d ready_at_done=%b",
                 it, obs_both, obs_stall_pulse, obs_hold, obs_notready, obs_done_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pull();
    test_stall();
    test_count_zero();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
